key_command_repeater: RTL

//  Turns level key signals from KeyboardControl (left/right/down/up/space) into discrete move commands for GameControl.

---
 rtl/key_command_repeater_pkg.sv | 30 +++
 rtl/key_command_repeater_if.sv | 29 ++
 rtl/key_command_repeater_hold_timer.sv | 30 +++
 rtl/key_command_repeater.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/key_command_repeater_pkg.sv
// rtl/key_command_repeater_pkg.sv - shared command codes, hold-state encoding and key priority helper
// Purpose: constants shared between the key repeater and the game controller.
// Contents: cmd_t, CMD_* codes, hold_state_t, active_key() priority encoder.
package key_command_repeater_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_NONE   = 3'b000;
  localparam cmd_t CMD_DOWN   = 3'b100;
  localparam cmd_t CMD_LEFT   = 3'b101;
  localparam cmd_t CMD_RIGHT  = 3'b110;
  localparam cmd_t CMD_ROTATE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLD_DAS    = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } hold_state_t;

  // Highest-priority held key: down > left > right > up.
  function automatic cmd_t active_key(input logic down, input logic left,
                                      input logic right, input logic up);
    if (down)       return CMD_DOWN;
    else if (left)  return CMD_LEFT;
    else if (right) return CMD_RIGHT;
    else if (up)    return CMD_ROTATE;
    else            return CMD_NONE;
  endfunction

endpackage

// File: rtl/key_command_repeater_if.sv
// rtl/key_command_repeater_if.sv - key levels in, move command handshake and reset request out
// Purpose: bundles the keyboard levels and the command valid/ready channel.
// Signals: left/right/down/up/space (key levels), cmd_ready (sink accepts),
//          cmd_valid/cmd (command channel), reset_req (game reset pulse).
// Modports: master = keyboard + game side, slave = key_command_repeater.
interface key_command_repeater_if;
  import key_command_repeater_pkg::*;

  logic left;
  logic right;
  logic down;
  logic up;
  logic space;
  logic cmd_ready;
  logic cmd_valid;
  cmd_t cmd;
  logic reset_req;

  modport master (
    output left, right, down, up, space, cmd_ready,
    input  cmd_valid, cmd, reset_req
  );

  modport slave (
    input  left, right, down, up, space, cmd_ready,
    output cmd_valid, cmd, reset_req
  );

endinterface

// File: rtl/key_command_repeater_hold_timer.sv
// rtl/key_command_repeater_hold_timer.sv - saturating clear/enable counter with terminal-count compare
// Purpose: counts enabled cycles since the last clear; never wraps.
// Ports: clk, rst (async, active-high), clear (sync, wins over enable),
//        enable, limit (terminal value), tc (count == limit).
module key_command_repeater_hold_timer #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/key_command_repeater.sv
// rtl/key_command_repeater.sv - key levels to one-shot plus auto-repeat move commands with skid slot
// Purpose: press -> one command, held key -> delayed auto-repeat, space -> debounced reset pulse.
// Ports: clk, rst (async, active-high), bus (key_command_repeater_if.slave):
//        key levels and cmd_ready in; cmd_valid, cmd, reset_req out.
module key_command_repeater
  import key_command_repeater_pkg::*;
#(
  parameter int DAS_DELAY     = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int DEBOUNCE      = 1_000_000,
  parameter int RESET_PULSE   = 16,
  parameter int CW            = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  key_command_repeater_if.slave  bus
);

  localparam int            PW     = $clog2(RESET_PULSE + 1);
  localparam logic [CW-1:0] DAS_TC = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] RPT_TC = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] DBC_TC = CW'(DEBOUNCE - 1);

  hold_state_t   state, state_nxt;
  cmd_t          held_key, held_key_nxt;
  cmd_t          active;
  logic          emit, emit_is_press;
  logic          rpt_clear, rpt_en, rpt_tc;
  logic [CW-1:0] rpt_limit;
  logic          dbc_tc, armed, fire, live, force_idle;
  logic [PW-1:0] pulse_cnt;
  logic          out_valid, skid_valid, xfer;
  cmd_t          out_cmd, skid_cmd;

  assign active = active_key(bus.down, bus.left, bus.right, bus.up);

  // live is low only until the first edge after rst, so nothing is emitted
  // from a key sampled on that edge.
  assign fire       = bus.space && armed && dbc_tc;
  assign force_idle = !live || (pulse_cnt != '0) || fire;
  assign rpt_limit  = (state == ST_HOLD_DAS) ? DAS_TC : RPT_TC;

  key_command_repeater_hold_timer #(.CW(CW)) u_repeat_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rpt_clear),
    .enable (rpt_en),
    .limit  (rpt_limit),
    .tc     (rpt_tc)
  );

  key_command_repeater_hold_timer #(.CW(CW)) u_debounce_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!bus.space),
    .enable (bus.space),
    .limit  (DBC_TC),
    .tc     (dbc_tc)
  );

  always_comb begin
    state_nxt     = state;
    held_key_nxt  = held_key;
    emit          = 1'b0;
    emit_is_press = 1'b0;
    rpt_clear     = 1'b0;
    rpt_en        = 1'b0;
    if (force_idle || (active == CMD_NONE)) begin
      state_nxt    = ST_IDLE;
      held_key_nxt = CMD_NONE;
      rpt_clear    = 1'b1;
    end else if ((state == ST_IDLE) || (active != held_key)) begin
      emit          = 1'b1;
      emit_is_press = 1'b1;
      state_nxt     = ST_HOLD_DAS;
      held_key_nxt  = active;
      rpt_clear     = 1'b1;
    end else if (state == ST_HOLD_DAS) begin
      // Rotate never auto-repeats; its timer just saturates.
      if (rpt_tc && (held_key != CMD_ROTATE)) begin
        emit      = 1'b1;
        state_nxt = ST_HOLD_REPEAT;
        rpt_clear = 1'b1;
      end else begin
        rpt_en = 1'b1;
      end
    end else begin
      if (rpt_tc) begin
        emit      = 1'b1;
        rpt_clear = 1'b1;
      end else begin
        rpt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      held_key  <= CMD_NONE;
      live      <= 1'b0;
      armed     <= 1'b1;
      pulse_cnt <= '0;
    end else begin
      state    <= state_nxt;
      held_key <= held_key_nxt;
      live     <= 1'b1;
      if (!bus.space) armed <= 1'b1;
      else if (fire)  armed <= 1'b0;
      if (fire)                   pulse_cnt <= PW'(RESET_PULSE);
      else if (pulse_cnt != '0)   pulse_cnt <= pulse_cnt - PW'(1);
    end
  end

  assign xfer = out_valid && bus.cmd_ready;

  // A fresh emit that can reach the output also discards the skid slot:
  // the newest command wins. While stalled, only presses are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_cmd    <= CMD_NONE;
      skid_valid <= 1'b0;
      skid_cmd   <= CMD_NONE;
    end else if (force_idle) begin
      out_valid  <= 1'b0;
      out_cmd    <= CMD_NONE;
      skid_valid <= 1'b0;
      skid_cmd   <= CMD_NONE;
    end else if (emit && (!out_valid || xfer)) begin
      out_valid  <= 1'b1;
      out_cmd    <= active;
      skid_valid <= 1'b0;
      skid_cmd   <= CMD_NONE;
    end else if (emit && emit_is_press) begin
      skid_valid <= 1'b1;
      skid_cmd   <= active;
    end else if (xfer) begin
      out_valid  <= skid_valid;
      out_cmd    <= skid_valid ? skid_cmd : CMD_NONE;
      skid_valid <= 1'b0;
      skid_cmd   <= CMD_NONE;
    end
  end

  assign bus.cmd_valid = out_valid;
  assign bus.cmd       = out_cmd;
  assign bus.reset_req = (pulse_cnt != '0);

endmodule
